// File: rtl/mux_word_serializer.sv
// mux_word_serializer
// Sequencer in front of an external mux_8to1. It accepts a byte on a
// valid/ready handshake and holds it on the mux data inputs. It then steps
// the mux select through all eight positions and hands each mux output bit
// downstream as a serial stream with valid/ready/last.
// Setting GAP (0..15) inserts that many idle cycles after every accepted bit.
// The last bit's gap is also honoured before the next word can load.
`timescale 1ns/1ps

module mux_word_serializer #(
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned GAP       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] mux_in,
    output logic [2:0] mux_sel,
    input  logic       mux_out,
    output logic       ser_bit,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // First select position of every word, and the direction it walks from there.
    localparam logic [2:0] SEL_START = MSB_FIRST ? 3'd7 : 3'd0;
    localparam bit         HAS_GAP   = (GAP > 0);
    // The gap counter runs 0..GAP_LAST, so it gives exactly GAP idle cycles.
    localparam logic [3:0] GAP_LAST  = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    state_t     state_reg,   state_next;
    logic [7:0] mux_in_reg,  mux_in_next;
    logic [2:0] mux_sel_reg, mux_sel_next;
    // The bit counter reaches 8 once the last bit of a word has been taken.
    // A GAP state can then tell whether any bits remain.
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [3:0] gap_cnt_reg, gap_cnt_next;

    logic [2:0] sel_step;
    logic       last_bit;

    assign sel_step = MSB_FIRST ? (mux_sel_reg - 3'd1) : (mux_sel_reg + 3'd1);
    assign last_bit = (bit_cnt_reg == 4'd7);

    // State and datapath registers; an asynchronous reset abandons any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            mux_in_reg  <= 8'h00;
            mux_sel_reg <= SEL_START;
            bit_cnt_reg <= 4'd0;
            gap_cnt_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            mux_in_reg  <= mux_in_next;
            mux_sel_reg <= mux_sel_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // Next-state, handshake outputs and datapath updates.
    // mux_in and mux_sel are left alone while a bit waits for ser_ready,
    // so ser_bit holds steady.
    always_comb begin
        state_next   = state_reg;
        mux_in_next  = mux_in_reg;
        mux_sel_next = mux_sel_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        in_ready     = 1'b0;
        ser_valid    = 1'b0;
        ser_last     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mux_in_next  = in_data;
                    mux_sel_next = SEL_START;
                    bit_cnt_next = 4'd0;
                    state_next   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_last  = last_bit;
                if (ser_ready) begin
                    if (!last_bit) begin
                        mux_sel_next = sel_step;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (HAS_GAP) begin
                            gap_cnt_next = 4'd0;
                            state_next   = ST_GAP;
                        end
                    end else if (HAS_GAP) begin
                        bit_cnt_next = 4'd8;
                        gap_cnt_next = 4'd0;
                        state_next   = ST_GAP;
                    end else begin
                        // Without a gap the next word may load in the
                        // same cycle as the last bit, with no bubble.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            mux_in_next  = in_data;
                            mux_sel_next = SEL_START;
                            bit_cnt_next = 4'd0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = (bit_cnt_reg == 4'd8) ? ST_IDLE : ST_SHIFT;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mux_in  = mux_in_reg;
    assign mux_sel = mux_sel_reg;
    assign ser_bit = mux_out;
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mux_word_serializer.sv
// tb_mux_word_serializer
// Three serializers: LSB-first with no gap, MSB-first with no gap, and
// LSB-first with GAP=2. Each one loops its select back through a behavioural
// 8:1 mux. A queue-based reference model predicts the outputs of every
// instance on every cycle. Per-phase statistics pin the directed scenarios to
// hand-computed literals.
`timescale 1ns/1ps

module tb_mux_word_serializer;

    localparam int N = 3;

    logic clk;
    logic rst0;
    logic rst_oth;
    logic [7:0] in_data_a   [N];
    logic       in_valid_a  [N];
    logic       in_ready_a  [N];
    logic [7:0] mux_in_a    [N];
    logic [2:0] mux_sel_a   [N];
    logic       mux_out_a   [N];
    logic       ser_bit_a   [N];
    logic       ser_valid_a [N];
    logic       ser_ready_a [N];
    logic       ser_last_a  [N];
    logic       busy_a      [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        mux_word_serializer #(
            .MSB_FIRST (gi == 1),
            .GAP       ((gi == 2) ? 2 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     ((gi == 0) ? rst0 : rst_oth),
            .in_data   (in_data_a[gi]),
            .in_valid  (in_valid_a[gi]),
            .in_ready  (in_ready_a[gi]),
            .mux_in    (mux_in_a[gi]),
            .mux_sel   (mux_sel_a[gi]),
            .mux_out   (mux_out_a[gi]),
            .ser_bit   (ser_bit_a[gi]),
            .ser_valid (ser_valid_a[gi]),
            .ser_ready (ser_ready_a[gi]),
            .ser_last  (ser_last_a[gi]),
            .busy      (busy_a[gi])
        );
        // Behavioural mux_8to1.
        assign mux_out_a[gi] = mux_in_a[gi][mux_sel_a[gi]];
    end

    function automatic int gap_of(int k);
        return (k == 2) ? 2 : 0;
    endfunction
    function automatic bit msb_of(int k);
        return (k == 1);
    endfunction
    function automatic int start_of(int k);
        return msb_of(k) ? 7 : 0;
    endfunction
    function automatic logic rst_of(int k);
        return (k == 0) ? rst0 : rst_oth;
    endfunction

    // Reference model: queue of pending bits, gap cooldown, current word.
    bit         mq  [N][$];
    int         mcd [N];
    logic [7:0] mwd [N];

    function automatic bit p_valid(int k);
        return (mq[k].size() > 0) && (mcd[k] == 0);
    endfunction
    function automatic bit p_ready(int k);
        if (mcd[k] != 0) return 1'b0;
        if (mq[k].size() == 0) return 1'b1;
        return (gap_of(k) == 0) && (mq[k].size() == 1) && ser_ready_a[k];
    endfunction
    function automatic int p_sel(int k);
        int dir;
        dir = msb_of(k) ? -1 : 1;
        return start_of(k) + dir * (8 - mq[k].size());
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!rst_of(k)) begin
                mq[k].delete();
                mcd[k] = 0;
                mwd[k] = 8'h00;
            end else begin
                bit acc_bit;
                bit acc_word;
                acc_bit  = p_valid(k) && ser_ready_a[k];
                acc_word = p_ready(k) && in_valid_a[k];
                if (mcd[k] > 0) mcd[k] = mcd[k] - 1;
                if (acc_bit) begin
                    void'(mq[k].pop_front());
                    mcd[k] = gap_of(k);
                end
                if (acc_word) begin
                    for (int i = 0; i < 8; i++)
                        mq[k].push_back(in_data_a[k][msb_of(k) ? 7 - i : i]);
                    mwd[k] = in_data_a[k];
                end
            end
        end
    end

    // Shared state between stimulus and checker.
    int   phase;
    int   ph_inst;
    bit   done;
    int   stim_timeouts;

    int   checks;
    int   errors;
    int   cyc_count;
    bit   by_clk;

    logic [31:0] seq_ph  [10];
    logic [23:0] sel_ph  [10];
    int          nacc    [10];
    int          nlast   [10];
    int          nbusy   [10];
    int          nvalid  [10];
    int          nstall  [10];
    int          nrdyb   [10];

    task automatic chk(string name, int k, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic final_checks();
        chk("ph1_seq",   0, int'(seq_ph[1]), 32'h55);
        chk("ph1_sels",  0, int'(sel_ph[1]), 24'o01234567);
        chk("ph1_nacc",  0, nacc[1], 8);
        chk("ph1_nlast", 0, nlast[1], 1);
        chk("ph1_busy",  0, nbusy[1], 8);
        chk("ph1_rdyb",  0, nrdyb[1], 1);
        chk("ph2_seq",   1, int'(seq_ph[2]), 32'hC1);
        chk("ph2_sels",  1, int'(sel_ph[2]), 24'o76543210);
        chk("ph2_busy",  1, nbusy[2], 8);
        chk("ph3_seq",   0, int'(seq_ph[3]), 32'hA5);
        chk("ph3_stall", 0, nstall[3], 3);
        chk("ph3_nacc",  0, nacc[3], 8);
        chk("ph3_busy",  0, nbusy[3], 11);
        chk("ph4_seq",   0, int'(seq_ph[4]), 32'hFF00);
        chk("ph4_nacc",  0, nacc[4], 16);
        chk("ph4_busy",  0, nbusy[4], 16);
        chk("ph4_rdyb",  0, nrdyb[4], 2);
        chk("ph4_nlast", 0, nlast[4], 2);
        chk("ph5_seq",   2, int'(seq_ph[5]), 32'hF0);
        chk("ph5_sels",  2, int'(sel_ph[5]), 24'o01234567);
        chk("ph5_valid", 2, nvalid[5], 8);
        chk("ph5_busy",  2, nbusy[5], 24);
        chk("ph7_valid", 0, nvalid[7], 0);
        chk("ph7_busy",  0, nbusy[7], 0);
        chk("ph8_seq",   0, int'(seq_ph[8]), 32'h81);
        chk("ph8_sels",  0, int'(sel_ph[8]), 24'o01234567);
        chk("ph8_nacc",  0, nacc[8], 8);
        chk("stim_timeouts", 0, stim_timeouts, 0);
    endtask

    // Single compare process: every falling clock edge, plus the instant after
    // instance 0's reset is asserted, so its asynchronous effect is checked
    // before the next rising edge.
    always begin
        @(negedge clk or negedge rst0);
        by_clk = (clk == 1'b0);
        #1;
        for (int k = 0; k < N; k++) begin
            if (!rst_of(k)) begin
                chk("rst_ser_valid", k, int'(ser_valid_a[k]), 0);
                chk("rst_ser_last",  k, int'(ser_last_a[k]), 0);
                chk("rst_busy",      k, int'(busy_a[k]), 0);
                chk("rst_in_ready",  k, int'(in_ready_a[k]), 1);
                chk("rst_mux_in",    k, int'(mux_in_a[k]), 0);
                chk("rst_mux_sel",   k, int'(mux_sel_a[k]), start_of(k));
            end else begin
                chk("ser_valid", k, int'(ser_valid_a[k]), int'(p_valid(k)));
                chk("in_ready",  k, int'(in_ready_a[k]), int'(p_ready(k)));
                chk("busy",      k, int'(busy_a[k]),
                    int'((mq[k].size() != 0) || (mcd[k] != 0)));
                chk("mux_in",    k, int'(mux_in_a[k]), int'(mwd[k]));
                if (p_valid(k)) begin
                    chk("ser_bit",  k, int'(ser_bit_a[k]), int'(mq[k][0]));
                    chk("ser_last", k, int'(ser_last_a[k]), int'(mq[k].size() == 1));
                    chk("mux_sel",  k, int'(mux_sel_a[k]), p_sel(k));
                end
            end
        end
        if (by_clk) begin
            if (phase > 0) begin
                if (busy_a[ph_inst]) nbusy[phase]++;
                if (ser_valid_a[ph_inst]) nvalid[phase]++;
                if (ser_valid_a[ph_inst] && !ser_ready_a[ph_inst]) nstall[phase]++;
                if (in_ready_a[ph_inst] && busy_a[ph_inst]) nrdyb[phase]++;
                if (ser_valid_a[ph_inst] && ser_ready_a[ph_inst]) begin
                    nacc[phase]++;
                    seq_ph[phase] = {seq_ph[phase][30:0], ser_bit_a[ph_inst]};
                    sel_ph[phase] = {sel_ph[phase][20:0], mux_sel_a[ph_inst]};
                    if (ser_last_a[ph_inst]) nlast[phase]++;
                end
            end
            cyc_count++;
            if (cyc_count > 30000) begin
                errors++;
                $display("FAIL watchdog cycles got %0d expected below 30000", cyc_count);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
            if (done) begin
                final_checks();
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    // Stimulus helpers, all driven from the one initial block below.
    task automatic wait_ready(int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready_a[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) stim_timeouts++;
    endtask

    task automatic send(int k, logic [7:0] d);
        in_valid_a[k] = 1'b1;
        in_data_a[k]  = d;
        wait_ready(k);
        @(posedge clk);
        #1;
        in_valid_a[k] = 1'b0;
        $display("send inst%0d data %02h at %0t", k, d, $time);
    endtask

    task automatic wait_idle(int k);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_a[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) stim_timeouts++;
    endtask

    task automatic wait_sel(int k, int s);
        int n;
        n = 0;
        @(negedge clk);
        while (!(ser_valid_a[k] && int'(mux_sel_a[k]) == s) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) stim_timeouts++;
    endtask

    task automatic next_phase(int k, int p);
        @(posedge clk);
        #1;
        ph_inst = k;
        phase   = p;
    endtask

    initial begin
        bit hs [N];
        checks = 0; errors = 0; cyc_count = 0;
        phase = 0; ph_inst = 0; done = 1'b0; stim_timeouts = 0;
        for (int p = 0; p < 10; p++) begin
            seq_ph[p] = '0; sel_ph[p] = '0; nacc[p] = 0; nlast[p] = 0;
            nbusy[p] = 0; nvalid[p] = 0; nstall[p] = 0; nrdyb[p] = 0;
        end
        rst0 = 1'b0;
        rst_oth = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_valid_a[k]  = 1'b0;
            in_data_a[k]   = 8'h00;
            ser_ready_a[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b1;
        rst_oth = 1'b1;
        repeat (2) @(posedge clk);

        // Basic LSB-first word.
        next_phase(0, 1);
        send(0, 8'b10101010);
        wait_idle(0);

        // MSB-first word.
        next_phase(1, 2);
        send(1, 8'b11000001);
        wait_idle(1);

        // Backpressure for 3 cycles on bit 2.
        next_phase(0, 3);
        send(0, 8'hA5);
        wait_sel(0, 2);
        ser_ready_a[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ser_ready_a[0] = 1'b1;
        wait_idle(0);

        // Back-to-back words with in_valid held.
        next_phase(0, 4);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 8'hFF;
        wait_ready(0);
        @(posedge clk);
        #1;
        in_data_a[0] = 8'h00;
        wait_ready(0);
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        $display("send inst0 data ff then 00 back-to-back at %0t", $time);
        wait_idle(0);

        // GAP=2 instance.
        next_phase(2, 5);
        send(2, 8'h0F);
        wait_idle(2);

        // Asynchronous reset while bit 4 is presented.
        next_phase(0, 6);
        send(0, 8'h3C);
        wait_sel(0, 4);
        ser_ready_a[0] = 1'b0;
        @(posedge clk);
        #2;
        rst0 = 1'b0;
        $display("reset asserted inst0 mid-word at %0t", $time);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst0 = 1'b1;
        ser_ready_a[0] = 1'b1;
        phase = 7;
        repeat (10) @(posedge clk);
        #1;

        // Fresh word after reset.
        phase = 8;
        send(0, 8'h81);
        wait_idle(0);

        // Randomized traffic on all instances together.
        next_phase(0, 0);
        for (int k = 0; k < N; k++) hs[k] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) hs[k] = in_valid_a[k] && in_ready_a[k];
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (hs[k]) $display("rand inst%0d accepted %02h at %0t", k, in_data_a[k], $time);
                ser_ready_a[k] = ($urandom_range(0, 3) != 0);
                if (hs[k] || !in_valid_a[k]) begin
                    in_valid_a[k] = ($urandom_range(0, 2) != 0);
                    in_data_a[k]  = 8'($urandom);
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            in_valid_a[k]  = 1'b0;
            ser_ready_a[k] = 1'b1;
        end
        repeat (40) @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
